// File: rtl/viterbi_chan_arbiter.sv
// Round-robin arbiter that shares one Viterbi decode path between N_CH channels.
// One channel holds the decoder input for a whole frame. A FIFO of channel tags,
// one per granted frame, labels each decoded byte with its source channel and
// marks the last byte of each frame.
module viterbi_chan_arbiter #(
    parameter int N_CH        = 2,
    parameter int CH_W        = 1,
    parameter int FRAME_WORDS = 8,
    parameter int TAG_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_valid_i,
    input  logic [16*N_CH-1:0]   ch_data_i,
    output logic [N_CH-1:0]      ch_ready_o,
    output logic                 dec_dvalid_o,
    output logic [15:0]          dec_data_o,
    input  logic                 dec_busy_i,
    input  logic                 dec_valid_i,
    input  logic [7:0]           dec_data_i,
    output logic                 out_valid_o,
    output logic [7:0]           out_data_o,
    output logic [CH_W-1:0]      out_ch_o,
    output logic                 out_last_o,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   grant;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_pick;
    logic              pick_found;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              tag_empty;
    logic              tag_full;
    logic              tag_push;
    logic              tag_pop;
    logic              xfer;
    logic              frame_done;
    logic              byte_ok;

    // Tag FIFO status: extra pointer MSB distinguishes full from empty.
    assign tag_empty = (wr_ptr == rd_ptr);
    assign tag_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Round-robin search: first valid channel after last_grant, wrapping.
    always_comb begin
        grant_pick = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!pick_found && ch_valid_i[k] &&
                    (k == (int'(last_grant) + i) % N_CH)) begin
                    grant_pick = CH_W'(k);
                    pick_found = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: grant in IDLE, leave BURST on the last word of the frame.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_found && !tag_full) state_next = S_BURST;
            S_BURST: if (frame_done)              state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic: only the granted channel sees ready, gated by decoder backpressure.
    always_comb begin
        ch_ready_o   = '0;
        dec_dvalid_o = 1'b0;
        if (state == S_BURST) begin
            for (int k = 0; k < N_CH; k++) begin
                if (grant == CH_W'(k)) begin
                    ch_ready_o[k] = ~dec_busy_i;
                    dec_dvalid_o  = ch_valid_i[k] & ~dec_busy_i;
                end
            end
        end
    end

    // Word mux from the granted channel to the decoder write port.
    always_comb begin
        dec_data_o = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant == CH_W'(k)) dec_data_o = ch_data_i[16*k +: 16];
        end
    end

    assign xfer       = dec_dvalid_o;
    assign frame_done = xfer && (word_cnt == LAST_CNT);
    assign tag_push   = (state == S_IDLE) && pick_found && !tag_full;
    assign byte_ok    = dec_valid_i && !tag_empty;
    assign tag_pop    = byte_ok && (byte_cnt == LAST_CNT);
    assign idle_o     = (state == S_IDLE) && tag_empty;

    // Grant bookkeeping and word counting for the frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant      <= '0;
            last_grant <= LAST_CH;
            word_cnt   <= '0;
        end else begin
            if (tag_push) begin
                grant    <= grant_pick;
                word_cnt <= '0;
            end else if (xfer) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (frame_done) last_grant <= grant;
        end
    end

    // Tag FIFO pointers; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tag_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (tag_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Tag FIFO storage.
    always_ff @(posedge clk) begin
        if (tag_push) tag_mem[wr_ptr[PTR_W-1:0]] <= grant_pick;
    end

    // Registered output tagging; orphan bytes are dropped and flagged sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_ch_o    <= '0;
            out_last_o  <= 1'b0;
            err_o       <= 1'b0;
            byte_cnt    <= '0;
        end else begin
            out_valid_o <= byte_ok;
            if (byte_ok) begin
                out_data_o <= dec_data_i;
                out_ch_o   <= tag_mem[rd_ptr[PTR_W-1:0]];
                out_last_o <= (byte_cnt == LAST_CNT);
                byte_cnt   <= (byte_cnt == LAST_CNT) ? '0 : byte_cnt + CNT_W'(1);
            end
            if (dec_valid_i && tag_empty) err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_viterbi_chan_arbiter.sv
// Self-checking bench for viterbi_chan_arbiter: randomized producers and a
// decoder stand-in, checked against a queue-based model of frames and tags.
module tb_viterbi_chan_arbiter;

    localparam int N_CH = 2;
    localparam int CH_W = 1;
    localparam int FW   = 8;
    localparam int TD   = 4;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   ch_valid_i;
    logic [16*N_CH-1:0] ch_data_i;
    logic [N_CH-1:0]   ch_ready_o;
    logic              dec_dvalid_o;
    logic [15:0]       dec_data_o;
    logic              dec_busy_i;
    logic              dec_valid_i;
    logic [7:0]        dec_data_i;
    logic              out_valid_o;
    logic [7:0]        out_data_o;
    logic [CH_W-1:0]   out_ch_o;
    logic              out_last_o;
    logic              idle_o;
    logic              err_o;

    viterbi_chan_arbiter #(.N_CH(N_CH), .CH_W(CH_W), .FRAME_WORDS(FW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i), .ch_ready_o(ch_ready_o),
        .dec_dvalid_o(dec_dvalid_o), .dec_data_o(dec_data_o), .dec_busy_i(dec_busy_i),
        .dec_valid_i(dec_valid_i), .dec_data_i(dec_data_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ch_o(out_ch_o),
        .out_last_o(out_last_o), .idle_o(idle_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Producer word streams and decoder stand-in contents.
    bit [15:0] chq [N_CH][$];
    bit [15:0] dec_fifo [$];
    int        tagq [$];
    int        dut_last_log [$];
    int        dut_dec_words = 0;

    // Frame-level model state.
    bit        m_active;
    int        m_g, m_wcnt, m_last, m_bcnt;
    bit        m_err;
    bit        e_ov, e_ol;
    bit [7:0]  e_od;
    int        e_oc;

    // Stimulus knobs.
    bit [N_CH-1:0] en;
    bit gap_en, busy_rand, busy_force, ret_en, ret_rand, err_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int rr_pick(input int last, input bit [N_CH-1:0] v);
        for (int i = 1; i <= N_CH; i++) begin
            int c;
            c = (last + i) % N_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit pending();
        bit p;
        p = m_active || (tagq.size() > 0);
        for (int k = 0; k < N_CH; k++)
            if (en[k] && chq[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        m_active = 0; m_g = 0; m_wcnt = 0; m_bcnt = 0;
        m_last = N_CH - 1; m_err = 0; e_ov = 0;
        tagq.delete();
        dec_fifo.delete();
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic cyc();
        bit [N_CH-1:0] v;
        bit [N_CH-1:0] exp_rdy;
        bit            exp_dv;
        int            sz;
        for (int k = 0; k < N_CH; k++) begin
            v[k] = !rst && en[k] && chq[k].size() > 0 && (!gap_en || $urandom_range(3) != 0);
            ch_data_i[16*k +: 16] = (chq[k].size() > 0) ? chq[k][0] : 16'($urandom);
        end
        ch_valid_i = v;
        dec_busy_i = busy_force || (busy_rand && $urandom_range(3) == 0);
        if (rst) begin
            dec_valid_i = 1'b0;
            dec_data_i  = 8'($urandom);
        end else if (err_pulse) begin
            dec_valid_i = 1'b1;
            dec_data_i  = 8'($urandom);
        end else if (ret_en && dec_fifo.size() > 0 && (!ret_rand || $urandom_range(1) == 1)) begin
            dec_valid_i = 1'b1;
            dec_data_i  = dec_fifo[0][7:0] ^ dec_fifo[0][15:8];
        end else begin
            dec_valid_i = 1'b0;
            dec_data_i  = 8'($urandom);
        end
        #1;
        if (rst) begin
            model_reset();
        end else begin
            exp_rdy = '0;
            exp_dv  = 1'b0;
            if (m_active) begin
                exp_rdy[m_g] = !dec_busy_i;
                exp_dv       = v[m_g] && !dec_busy_i;
            end
            chk("ch_ready", ch_ready_o, exp_rdy);
            chk("dec_dvalid", dec_dvalid_o, exp_dv);
            if (exp_dv) chk("dec_data", dec_data_o, chq[m_g][0]);
            chk("idle", idle_o, (!m_active && tagq.size() == 0));
            if (dec_dvalid_o === 1'b1) dut_dec_words++;

            sz = tagq.size();
            e_ov = 0;
            if (dec_valid_i) begin
                if (sz > 0) begin
                    e_ov = 1; e_od = dec_data_i; e_oc = tagq[0]; e_ol = (m_bcnt == FW-1);
                    if (dec_fifo.size() > 0) void'(dec_fifo.pop_front());
                    if (m_bcnt == FW-1) begin
                        m_bcnt = 0;
                        void'(tagq.pop_front());
                    end else begin
                        m_bcnt++;
                    end
                end else begin
                    m_err = 1;
                end
            end
            if (!m_active) begin
                if (v != '0 && sz < TD) begin
                    m_g = rr_pick(m_last, v);
                    tagq.push_back(m_g);
                    m_active = 1; m_wcnt = 0;
                end
            end else if (exp_dv) begin
                dec_fifo.push_back(chq[m_g].pop_front());
                m_wcnt++;
                if (m_wcnt == FW) begin
                    m_active = 0;
                    m_last = m_g;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid_o, e_ov);
        if (e_ov) begin
            chk("out_data", out_data_o, e_od);
            chk("out_ch", out_ch_o, e_oc);
            chk("out_last", out_last_o, e_ol);
        end
        chk("err", err_o, m_err);
        if (rst) begin
            chk("rst_out_data", out_data_o, 0);
            chk("rst_out_ch", out_ch_o, 0);
            chk("rst_out_last", out_last_o, 0);
        end
        if (out_valid_o === 1'b1 && out_last_o === 1'b1) dut_last_log.push_back(int'(out_ch_o));
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (pending() && n < max_cyc) begin
            cyc();
            n++;
        end
        chk("drain_done", pending(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int l0;
        rst = 1'b1; ch_valid_i = '0; ch_data_i = '0; dec_busy_i = 1'b0;
        dec_valid_i = 1'b0; dec_data_i = '0;
        en = '0; gap_en = 0; busy_rand = 0; busy_force = 0;
        ret_en = 1; ret_rand = 0; err_pulse = 0;
        model_reset();
        @(negedge clk);

        // Reset and quiet cycles.
        do_reset();
        do_reset();
        cyc();
        cyc();

        // Single channel, words 0..7, free-flowing decoder.
        for (int i = 0; i < FW; i++) chq[0].push_back(16'(i));
        en = 2'b01; ret_rand = 1;
        d0 = dut_dec_words; l0 = dut_last_log.size();
        drain(100);
        cyc();
        chk("t1_words", dut_dec_words - d0, FW);
        chk("t1_frames", dut_last_log.size() - l0, 1);
        if (dut_last_log.size() > l0) chk("t1_last_ch", dut_last_log[l0], 0);

        // Round robin with both channels continuously valid, from reset.
        do_reset();
        for (int k = 0; k < N_CH; k++)
            for (int i = 0; i < 2*FW; i++) chq[k].push_back(16'($urandom));
        en = 2'b11;
        l0 = dut_last_log.size();
        drain(300);
        chk("t2_frames", dut_last_log.size() - l0, 4);
        for (int f = 0; f < 4; f++)
            if (dut_last_log.size() > l0 + f) chk("t2_order", dut_last_log[l0+f], f % 2);

        // Gappy valids and random backpressure.
        gap_en = 1; busy_rand = 1;
        for (int k = 0; k < N_CH; k++)
            for (int i = 0; i < 2*FW; i++) chq[k].push_back(16'($urandom));
        drain(600);
        gap_en = 0; busy_rand = 0;

        // Backpressure for 3 cycles at word 4 of a ch1 frame.
        for (int i = 0; i < FW; i++) chq[1].push_back(16'($urandom));
        en = 2'b10;
        d0 = dut_dec_words;
        for (int n = 0; n < 50 && !(m_active && m_wcnt == 4); n++) cyc();
        chk("t3_reached_w4", (m_active && m_wcnt == 4), 1);
        busy_force = 1;
        repeat (3) cyc();
        busy_force = 0;
        drain(100);
        chk("t3_words", dut_dec_words - d0, FW);

        // Tag FIFO full with the decoder output stalled.
        ret_en = 0; ret_rand = 0;
        for (int i = 0; i < 3*FW; i++) chq[0].push_back(16'($urandom));
        for (int i = 0; i < 2*FW; i++) chq[1].push_back(16'($urandom));
        en = 2'b11;
        d0 = dut_dec_words;
        repeat (60) cyc();
        chk("t4_held_words", dut_dec_words - d0, TD*FW);
        chk("t4_full_idle", idle_o, 0);
        ret_en = 1;
        drain(500);
        chk("t4_all_words", dut_dec_words - d0, 5*FW);
        cyc();

        // Orphan decoded byte.
        err_pulse = 1;
        cyc();
        err_pulse = 0;
        repeat (3) cyc();
        chk("t5_err_sticky", err_o, 1);
        do_reset();
        chk("t5_err_cleared", err_o, 0);
        cyc();

        // Reset in the middle of a ch0 frame, then a full ch1 frame.
        for (int i = 0; i < FW; i++) chq[0].push_back(16'($urandom));
        en = 2'b01; ret_rand = 1;
        for (int n = 0; n < 50 && !(m_active && m_wcnt == 3); n++) cyc();
        chk("t6_reached_w3", (m_active && m_wcnt == 3), 1);
        en = 2'b00;
        do_reset();
        chq[0].delete();
        cyc();
        chk("t6_idle", idle_o, 1);
        for (int i = 0; i < FW; i++) chq[1].push_back(16'($urandom));
        en = 2'b10;
        d0 = dut_dec_words; l0 = dut_last_log.size();
        drain(100);
        cyc();
        chk("t6_words", dut_dec_words - d0, FW);
        chk("t6_frames", dut_last_log.size() - l0, 1);
        if (dut_last_log.size() > l0) chk("t6_last_ch", dut_last_log[l0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_chan_arbiter.md
Name: viterbi_chan_arbiter

Overview:
- Shares one Viterbi decode subsystem (input FIFO → PISO → Viterbi core → SIPO) between N_CH requester channels.
- Grants the decoder input to one channel per frame, round-robin, and forwards that channel's 16-bit words into the decoder's write port while honouring its busy backpressure.
- Keeps an in-order FIFO of channel tags, one per granted frame, so every decoded output byte is labelled with its source channel and a last-byte-of-frame marker.
- Sits between the per-channel producers/consumers and the decode subsystem top.

Parameters:
N_CH, 2, number of requester channels
CH_W, 1, channel-ID width; requirement CH_W ≥ clog2(N_CH)
FRAME_WORDS, 8, 16-bit input words per frame; also the number of decoded bytes per frame (1 word → 1 byte)
TAG_DEPTH, 4, tag FIFO depth, i.e. maximum frames in flight; power of 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
ch_valid_i  in  N_CH  per-channel word valid
ch_data_i  in  16*N_CH  per-channel word; channel k occupies bits [16k+15:16k]
ch_ready_o  out  N_CH  per-channel ready; a word transfers when valid&ready
dec_dvalid_o  out  1  write strobe to the decoder input FIFO
dec_data_o  out  16  word to the decoder
dec_busy_i  in  1  decoder input FIFO full
dec_valid_i  in  1  decoded byte valid from the decoder
dec_data_i  in  8  decoded byte
out_valid_o  out  1  tagged byte valid
out_data_o  out  8  tagged byte
out_ch_o  out  CH_W  source channel of the byte
out_last_o  out  1  byte is the final byte of its frame
idle_o  out  1  FSM in IDLE and tag FIFO empty
err_o  out  1  sticky: decoded byte arrived with no open frame

Behaviour:
- Reset (rst=1 at a clk edge) clears the following:
  - FSM goes to IDLE.
  - word_cnt, byte_cnt and the tag FIFO pointers go to 0.
  - last_grant goes to N_CH-1, so channel 0 wins first.
  - out_valid_o, out_data_o, out_ch_o, out_last_o and err_o go to 0.
  - A frame in progress at reset is abandoned; there is no partial-frame recovery.
- ch_ready_o, dec_dvalid_o and dec_data_o are combinational.
  - Reset-state values: ch_ready_o=0, dec_dvalid_o=0.
  - dec_data_o equals the granted channel's word; it is don't-care when dec_dvalid_o=0.
- FSM IDLE:
  - Grant condition: any ch_valid_i bit is set and the tag FIFO is not full.
  - On grant, pick the first valid channel searching last_grant+1, +2, … modulo N_CH.
  - Register grant=g, push g into the tag FIFO, set word_cnt=0, go to BURST.
  - No word transfers in the IDLE cycle.
- FSM BURST:
  - ch_ready_o[g] = ~dec_busy_i. All other ready bits are 0.
  - dec_dvalid_o = ch_valid_i[g] & ~dec_busy_i.
  - Each transfer increments word_cnt.
  - The transfer with word_cnt==FRAME_WORDS-1 ends the frame: set last_grant=g and return to IDLE.
  - The next grant happens no earlier than the following cycle, giving minimum 1 bubble per frame.
  - A granted channel may deassert valid mid-frame. The grant is held and no timeout applies.
- Output tagging, 1-cycle registered latency:
  - On dec_valid_i with the tag FIFO non-empty, next cycle: out_valid_o=1, out_data_o=dec_data_i, out_ch_o=tag FIFO head, out_last_o=(byte_cnt==FRAME_WORDS-1).
  - byte_cnt increments per byte. On the last byte it wraps to 0 and the head tag is popped.
  - dec_valid_i with the tag FIFO empty: drop the byte, out_valid_o=0, set err_o=1. err_o clears only on rst.
- Tag FIFO:
  - Push (IDLE grant) and pop (last byte) in the same cycle are both performed, and the count is unchanged.
  - A grant when the FIFO is empty and a pop in the same cycle cannot occur, because a pop requires non-empty.
  - When full, IDLE holds without granting; in-flight frames drain through pops.
  - Pointers wrap modulo TAG_DEPTH.
- Channels with no ch_valid_i are skipped. A single active channel is regranted back-to-back, with 1 bubble between frames.

Test Plan:
- Single channel: ch0 sends 8 words 0x0000..0x0007, dec_busy_i=0.
  - Required: dec_dvalid_o high for 8 consecutive cycles with matching data.
  - Required: a model decoder returns 8 bytes → 8 out_valid_o pulses, out_ch_o=0, out_last_o only on the 8th byte; idle_o=1 afterwards.
- Round-robin: ch0 and ch1 both continuously valid for 4 frames.
  - Required: grant order 0,1,0,1; tag FIFO order matches; out_ch_o sequence per frame is 0,1,0,1.
- Backpressure: dec_busy_i=1 for 3 cycles during word 4 of a ch1 frame.
  - Required: ch_ready_o[1]=0 and dec_dvalid_o=0 for those 3 cycles.
  - Required: exactly 8 words reach the decoder, none duplicated or lost.
- Tag full: grant 4 frames with the decoder output stalled.
  - Required: the 5th request is not granted; ch_ready_o stays 0.
  - Required: after 8 bytes are returned (pop), the 5th frame is granted, including when the grant coincides with the pop cycle.
- Error: dec_valid_i pulse with no frame granted.
  - Required: err_o=1 from the next cycle and stays high; out_valid_o stays 0; rst clears err_o.
- Mid-frame reset: assert rst after word 3 of a ch0 frame.
  - Required: all outputs return to reset values next cycle, idle_o=1.
  - Required: a new request from ch1 alone is granted and completes a full 8-word frame.
